// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue
// Instruction-fetch front end. It issues sequential reads to a synchronous
// instruction SRAM with a 1-cycle read latency and buffers the returned
// {pc, inst} pairs in a DEPTH-entry FIFO. Decode drains the FIFO through a
// valid/ready handshake.
//
// A single redirect port flushes everything that is queued or in flight. A
// misaligned redirect target turns into one address-error entry, and fetch
// then stops until the next redirect.
//
// Optional build macro PREFETCH_BYPASS_EN: when the queue is empty, a
// returning SRAM response is presented to decode in the same cycle it
// arrives. Without the macro, decode only ever sees queue storage.

module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic                       clk,
    input  logic                       resetn,
    output logic                       inst_sram_en,
    output logic [31:0]                inst_sram_addr,
    input  logic [31:0]                inst_sram_rdata,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       de_ready,
    output logic                       de_valid,
    output logic [31:0]                de_pc,
    output logic [31:0]                de_inst,
    output logic                       de_adel,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Fetch state
    logic [31:0]    fetch_pc_r;
    logic [31:0]    req_pc_r;
    logic           inflight_r;
    logic           halt_r;

    // Queue state
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [CW-1:0]  count_r;
    logic [31:0]    pc_mem_r   [DEPTH];
    logic [31:0]    inst_mem_r [DEPTH];
    logic [DEPTH-1:0] adel_mem_r;

    // Control decoded each cycle
    logic [CW-1:0]  occ_s;
    logic           issue_s;
    logic           resp_s;
    logic           nonempty_s;
    logic           bypass_s;
    logic           pop_s;
    logic           push_s;
    logic           misaligned_s;

    // Issue, response, push and pop decisions; redirect overrides all of them
    always_comb begin
        occ_s        = count_r + {{PW{1'b0}}, inflight_r};
        misaligned_s = (redirect_pc[1:0] != 2'b00);
        issue_s      = resetn & ~redirect_valid & ~halt_r & (occ_s < DEPTH_C);
        resp_s       = inflight_r & ~redirect_valid;
        nonempty_s   = (count_r != {CW{1'b0}});
`ifdef PREFETCH_BYPASS_EN
        bypass_s     = resp_s & ~nonempty_s;
`else
        bypass_s     = 1'b0;
`endif
        pop_s        = nonempty_s & de_ready;
        // A bypassed response that decode takes immediately is never stored
        push_s       = resp_s & ~(bypass_s & de_ready);
    end

    // Decode-side view: the queue head, or the live response when bypassing
    always_comb begin
        de_valid = nonempty_s | bypass_s;
        de_pc    = 32'h0000_0000;
        de_inst  = 32'h0000_0000;
        de_adel  = 1'b0;
        if (nonempty_s) begin
            de_pc   = pc_mem_r[rd_ptr_r];
            de_inst = inst_mem_r[rd_ptr_r];
            de_adel = adel_mem_r[rd_ptr_r];
        end else if (bypass_s) begin
            de_pc   = req_pc_r;
            de_inst = inst_sram_rdata;
            de_adel = 1'b0;
        end else begin
            de_pc   = 32'h0000_0000;
            de_inst = 32'h0000_0000;
            de_adel = 1'b0;
        end
    end

    assign inst_sram_en   = issue_s;
    assign inst_sram_addr = fetch_pc_r;
    assign q_count        = count_r;

    // Fetch PC, outstanding request tracking and fault halt
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= 32'h0000_0000;
            inflight_r <= 1'b0;
            halt_r     <= 1'b0;
        end else if (redirect_valid) begin
            inflight_r <= 1'b0;
            halt_r     <= misaligned_s;
            // A misaligned target never reaches the SRAM; fetch_pc is left alone
            if (!misaligned_s) begin
                fetch_pc_r <= redirect_pc;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
        end else if (issue_s) begin
            fetch_pc_r <= fetch_pc_r + 32'd4;
            req_pc_r   <= fetch_pc_r;
            inflight_r <= 1'b1;
        end else begin
            inflight_r <= 1'b0;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (redirect_valid) begin
            rd_ptr_r <= {PW{1'b0}};
            // A fault entry occupies slot 0
            if (misaligned_s) begin
                wr_ptr_r <= PW'(1);
                count_r  <= CW'(1);
            end else begin
                wr_ptr_r <= {PW{1'b0}};
                count_r  <= {CW{1'b0}};
            end
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage: a fault entry on a misaligned redirect, else responses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= 32'h0000_0000;
                inst_mem_r[i] <= 32'h0000_0000;
            end
            adel_mem_r <= {DEPTH{1'b0}};
        end else if (redirect_valid) begin
            if (misaligned_s) begin
                pc_mem_r[0]   <= redirect_pc;
                inst_mem_r[0] <= 32'h0000_0000;
                adel_mem_r[0] <= 1'b1;
            end else begin
                adel_mem_r <= adel_mem_r;
            end
        end else if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= req_pc_r;
            inst_mem_r[wr_ptr_r] <= inst_sram_rdata;
            adel_mem_r[wr_ptr_r] <= 1'b0;
        end else begin
            adel_mem_r <= adel_mem_r;
        end
    end

endmodule
